// File: rtl/shift_pkg.sv
// shift_pkg: op codes and helpers shared by the pipelined shifter.
// Payload layout (MSB..LSB): data, op, cnt, carry, err.
package shift_pkg;

   typedef enum logic [2:0] {
      OP_LSL = 3'd0,
      OP_LSR = 3'd1,
      OP_ASL = 3'd2,
      OP_ASR = 3'd3,
      OP_ROL = 3'd4,
      OP_ROR = 3'd5
   } shift_op_e;

   localparam int CNT_LSB = 2;

   function automatic logic is_valid_op(input logic [2:0] op);
      return op <= OP_ROR;
   endfunction

   function automatic int payload_bits(input int width);
      return width + 3 + $clog2(width) + 2;
   endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// shift_pipe_if: request/result handshake bundle of the shifter.
// slave = shifter side, master = requester/consumer side.
interface shift_pipe_if #(
   parameter int WIDTH = 32
);
   localparam int CW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [2:0]       in_op;
   logic [CW-1:0]    in_cnt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_carry;
   logic             out_zero;
   logic             out_err;

   modport master (
      output in_valid, in_data, in_op, in_cnt, out_ready,
      input  in_ready, out_valid, out_data, out_carry,
      input  out_zero, out_err
   );

   modport slave (
      input  in_valid, in_data, in_op, in_cnt, out_ready,
      output in_ready, out_valid, out_data, out_carry,
      output out_zero, out_err
   );

endinterface

// File: rtl/shift_level.sv
// shift_level: one combinational shift level of SHAMT positions.
// Ports: src payload, en (cnt bit), dst payload.
module shift_level
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHAMT = 1
) (
   input  logic [payload_bits(WIDTH)-1:0] src,
   input  logic                           en,
   output logic [payload_bits(WIDTH)-1:0] dst
);
   localparam int CW = $clog2(WIDTH);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [2:0]       op;
      logic [CW-1:0]    cnt;
      logic             carry;
      logic             err;
   } stage_payload_t;

   stage_payload_t   pi;
   stage_payload_t   po;
   logic [WIDTH-1:0] rot_l;
   logic [WIDTH-1:0] rot_r;

   assign pi    = src;
   assign dst   = po;
   assign rot_l = (pi.data << SHAMT) | (pi.data >> (WIDTH - SHAMT));
   assign rot_r = (pi.data >> SHAMT) | (pi.data << (WIDTH - SHAMT));

   // Carry always tracks the last bit moved out by an enabled level,
   // so the final value is the one from the highest enabled level.
   always_comb begin
      po = pi;
      if (en && !pi.err) begin
         unique case (1'b1)
            (pi.op == OP_LSL) || (pi.op == OP_ASL): begin
               po.data  = pi.data << SHAMT;
               po.carry = pi.data[WIDTH-SHAMT];
            end
            (pi.op == OP_LSR): begin
               po.data  = pi.data >> SHAMT;
               po.carry = pi.data[SHAMT-1];
            end
            (pi.op == OP_ASR): begin
               po.data  = $signed(pi.data) >>> SHAMT;
               po.carry = pi.data[SHAMT-1];
            end
            (pi.op == OP_ROL): begin
               po.data  = rot_l;
               po.carry = rot_l[0];
            end
            (pi.op == OP_ROR): begin
               po.data  = rot_r;
               po.carry = rot_r[WIDTH-1];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: elastic pipelined shifter, PIPE register stages.
// Ports: clk, reset_n (async low), bus (shift_pipe_if.slave).
module shift_pipe
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int PIPE  = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   shift_pipe_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);
   localparam int L  = (CW + PIPE - 1) / PIPE;
   localparam int PW = payload_bits(WIDTH);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [2:0]       op;
      logic [CW-1:0]    cnt;
      logic             carry;
      logic             err;
   } stage_payload_t;

   stage_payload_t  entry;
   stage_payload_t  fin;
   logic [PW-1:0]   sout [PIPE];
   logic [PW-1:0]   stg  [PIPE];
   logic [PIPE-1:0] v;
   logic [PIPE-1:0] adv;
   logic [PIPE:0]   up_v;
   logic            zero_q;
   logic            unused_bits;

   // Invalid ops enter as a zero result with err set; the levels
   // leave errored payloads untouched.
   always_comb begin
      entry       = '0;
      entry.data  = is_valid_op(bus.in_op) ? bus.in_data : '0;
      entry.op    = bus.in_op;
      entry.cnt   = bus.in_cnt;
      entry.carry = 1'b0;
      entry.err   = ~is_valid_op(bus.in_op);
   end

   for (genvar s = 0; s < PIPE; s++) begin : g_stg
      logic [PW-1:0] lv [L+1];

      if (s == 0) begin : g_head
         assign lv[0] = entry;
      end else begin : g_link
         assign lv[0] = stg[s-1];
      end

      for (genvar i = 0; i < L; i++) begin : g_lvl
         localparam int J = s * L + i;
         if (J < CW) begin : g_on
            // en is cnt bit J of the travelling payload
            shift_level #(
               .WIDTH (WIDTH),
               .SHAMT (1 << J)
            ) u_lvl (
               .src (lv[i]),
               .en  (lv[i][CNT_LSB+J]),
               .dst (lv[i+1])
            );
         end else begin : g_pass
            assign lv[i+1] = lv[i];
         end
      end

      assign sout[s] = lv[L];
   end

   // A stage may load if everything from it to the output can move.
   for (genvar k = 0; k < PIPE; k++) begin : g_adv
      assign adv[k] = bus.out_ready | ~(&v[PIPE-1:k]);
   end

   assign up_v = {v, bus.in_valid};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v      <= '0;
         zero_q <= 1'b0;
         for (int k = 0; k < PIPE; k++) begin
            stg[k] <= '0;
         end
      end else begin
         for (int k = 0; k < PIPE; k++) begin
            if (adv[k]) begin
               v[k]   <= up_v[k];
               stg[k] <= sout[k];
            end
         end
         if (adv[PIPE-1]) begin
            zero_q <= ~|sout[PIPE-1][PW-1 -: WIDTH];
         end
      end
   end

   assign fin           = stg[PIPE-1];
   assign bus.in_ready  = adv[0];
   assign bus.out_valid = v[PIPE-1];
   assign bus.out_data  = fin.data;
   assign bus.out_carry = fin.carry;
   assign bus.out_zero  = zero_q;
   assign bus.out_err   = fin.err;
   assign unused_bits   = ^{fin.op, fin.cnt};

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed + random checks of shift_pipe against a
// bit-permutation reference model, three parameter sets.
module tb_shift_pipe;
   import shift_pkg::*;

   typedef struct {
      logic [127:0] d;
      logic         c;
      logic         e;
      int           acc;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   shift_pipe_if #(.WIDTH(32)) ia ();
   shift_pipe_if #(.WIDTH(8))  ib ();
   shift_pipe_if #(.WIDTH(64)) ic ();

   shift_pipe #(.WIDTH(32), .PIPE(2)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(ia.slave));
   shift_pipe #(.WIDTH(8), .PIPE(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(ib.slave));
   shift_pipe #(.WIDTH(64), .PIPE(6)) dut_c (
      .clk(clk), .reset_n(reset_n), .bus(ic.slave));

   // Reference: result bit i is picked directly from the operand.
   function automatic exp_t mk(input logic [127:0] d,
                               input logic [2:0] op,
                               input int n, input int w,
                               input int acc);
      exp_t r;
      logic [127:0] o;
      o = '0;
      r.acc = acc;
      r.e = 1'b0;
      r.c = 1'b0;
      case (op)
         3'd0, 3'd2: begin
            for (int i = 0; i < w; i++)
               if (i >= n) o[i] = d[i-n];
            if (n > 0) r.c = d[w-n];
         end
         3'd1, 3'd3: begin
            for (int i = 0; i < w; i++)
               if (i + n < w) o[i] = d[i+n];
               else o[i] = (op == 3'd3) ? d[w-1] : 1'b0;
            if (n > 0) r.c = d[n-1];
         end
         3'd4: begin
            for (int i = 0; i < w; i++) o[i] = d[(i - n + w) % w];
            if (n > 0) r.c = o[0];
         end
         3'd5: begin
            for (int i = 0; i < w; i++) o[i] = d[(i + n) % w];
            if (n > 0) r.c = o[w-1];
         end
         default: r.e = 1'b1;
      endcase
      r.d = o;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout got none want handshake", nm);
   endtask

   task automatic cmp_out(input string nm, input exp_t e,
                          input logic [127:0] d, input logic c,
                          input logic z, input logic er,
                          input int p, input bit lat);
      chk({nm, "_data"}, d, e.d);
      chk({nm, "_carry"}, 128'(c), 128'(e.c));
      chk({nm, "_zero"}, 128'(z), 128'(e.d == '0));
      chk({nm, "_err"}, 128'(er), 128'(e.e));
      if (lat) chk({nm, "_lat"}, 128'(cyc - e.acc), 128'(p));
   endtask

   exp_t qa[$], qb[$], qc[$];
   bit   la = 1'b1, lb = 1'b1, lc = 1'b1;
   int   popa = 0, popb = 0, popc = 0;
   int   acca = 0, accb = 0, accc = 0;

   initial begin
      bit sa = 0;
      logic [35:0] pa;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            qa.delete();
            sa = 0;
         end else begin
            if (sa) chk("a_hold", 128'({ia.out_valid, ia.out_data,
               ia.out_carry, ia.out_zero, ia.out_err}), 128'(pa));
            if (ia.out_valid && ia.out_ready) begin
               popa++;
               chk("a_queue", 128'(qa.size() != 0), 128'(1));
               if (qa.size() != 0) begin
                  e = qa.pop_front();
                  cmp_out("a", e, 128'(ia.out_data), ia.out_carry,
                          ia.out_zero, ia.out_err, 2, la);
               end
            end
            if (ia.in_valid && ia.in_ready) begin
               qa.push_back(mk(128'(ia.in_data), ia.in_op,
                               int'(ia.in_cnt), 32, cyc));
               acca++;
            end
            sa = ia.out_valid && !ia.out_ready;
            pa = {ia.out_valid, ia.out_data, ia.out_carry,
                  ia.out_zero, ia.out_err};
         end
      end
   end

   initial begin
      bit sb = 0;
      logic [11:0] pb;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            qb.delete();
            sb = 0;
         end else begin
            if (sb) chk("b_hold", 128'({ib.out_valid, ib.out_data,
               ib.out_carry, ib.out_zero, ib.out_err}), 128'(pb));
            if (ib.out_valid && ib.out_ready) begin
               popb++;
               chk("b_queue", 128'(qb.size() != 0), 128'(1));
               if (qb.size() != 0) begin
                  e = qb.pop_front();
                  cmp_out("b", e, 128'(ib.out_data), ib.out_carry,
                          ib.out_zero, ib.out_err, 1, lb);
               end
            end
            if (ib.in_valid && ib.in_ready) begin
               qb.push_back(mk(128'(ib.in_data), ib.in_op,
                               int'(ib.in_cnt), 8, cyc));
               accb++;
            end
            sb = ib.out_valid && !ib.out_ready;
            pb = {ib.out_valid, ib.out_data, ib.out_carry,
                  ib.out_zero, ib.out_err};
         end
      end
   end

   initial begin
      bit sc = 0;
      logic [67:0] pc;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            qc.delete();
            sc = 0;
         end else begin
            if (sc) chk("c_hold", 128'({ic.out_valid, ic.out_data,
               ic.out_carry, ic.out_zero, ic.out_err}), 128'(pc));
            if (ic.out_valid && ic.out_ready) begin
               popc++;
               chk("c_queue", 128'(qc.size() != 0), 128'(1));
               if (qc.size() != 0) begin
                  e = qc.pop_front();
                  cmp_out("c", e, 128'(ic.out_data), ic.out_carry,
                          ic.out_zero, ic.out_err, 6, lc);
               end
            end
            if (ic.in_valid && ic.in_ready) begin
               qc.push_back(mk(128'(ic.in_data), ic.in_op,
                               int'(ic.in_cnt), 64, cyc));
               accc++;
            end
            sc = ic.out_valid && !ic.out_ready;
            pc = {ic.out_valid, ic.out_data, ic.out_carry,
                  ic.out_zero, ic.out_err};
         end
      end
   end

   // Called just after a rising edge; returns just after the
   // edge that accepted the request.
   task automatic send_a(input logic [31:0] d, input logic [2:0] op,
                         input logic [4:0] n);
      int t = 0;
      ia.in_valid = 1'b1;
      ia.in_data  = d;
      ia.in_op    = op;
      ia.in_cnt   = n;
      @(negedge clk);
      while (!ia.in_ready && t < 100) begin
         t++;
         @(negedge clk);
      end
      if (t >= 100) timeout("a_send");
      @(posedge clk);
      #1;
      ia.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic run_b(input int n, input bit rr);
      int sent = 0;
      int g = 0;
      bit took = 0;
      while (sent < n && g < 5000) begin
         @(posedge clk);
         #1;
         g++;
         if (took) ib.in_valid = 1'b0;
         ib.out_ready = rr ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (!ib.in_valid && $urandom_range(0, 3) != 0) begin
            ib.in_valid = 1'b1;
            ib.in_data  = 8'($urandom);
            ib.in_op    = 3'($urandom);
            ib.in_cnt   = 3'($urandom);
         end
         @(negedge clk);
         took = ib.in_valid && ib.in_ready;
         if (took) sent++;
      end
      @(posedge clk);
      #1;
      ib.in_valid  = 1'b0;
      ib.out_ready = 1'b1;
      if (sent < n) timeout("b_run");
   endtask

   task automatic run_c(input int n, input bit rr);
      int sent = 0;
      int g = 0;
      bit took = 0;
      while (sent < n && g < 5000) begin
         @(posedge clk);
         #1;
         g++;
         if (took) ic.in_valid = 1'b0;
         ic.out_ready = rr ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (!ic.in_valid && $urandom_range(0, 3) != 0) begin
            ic.in_valid = 1'b1;
            ic.in_data  = {$urandom, $urandom};
            ic.in_op    = 3'($urandom);
            ic.in_cnt   = 6'($urandom);
         end
         @(negedge clk);
         took = ic.in_valid && ic.in_ready;
         if (took) sent++;
      end
      @(posedge clk);
      #1;
      ic.in_valid  = 1'b0;
      ic.out_ready = 1'b1;
      if (sent < n) timeout("c_run");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t m;
      int p0;
      int seen;
      ia.in_valid = 0; ia.in_data = '0; ia.in_op = '0;
      ia.in_cnt = '0; ia.out_ready = 1;
      ib.in_valid = 0; ib.in_data = '0; ib.in_op = '0;
      ib.in_cnt = '0; ib.out_ready = 1;
      ic.in_valid = 0; ic.in_data = '0; ic.in_op = '0;
      ic.in_cnt = '0; ic.out_ready = 1;
      #1 reset_n = 1'b0;
      #11;
      chk("rst_valid", 128'(ia.out_valid), 0);
      chk("rst_data", 128'(ia.out_data), 0);
      chk("rst_carry", 128'(ia.out_carry), 0);
      chk("rst_zero", 128'(ia.out_zero), 0);
      chk("rst_err", 128'(ia.out_err), 0);
      chk("rst_ready", 128'(ia.in_ready), 1);
      chk("rst_b_valid", 128'(ib.out_valid), 0);
      chk("rst_c_valid", 128'(ic.out_valid), 0);

      // Pin the model with hand-derived results.
      m = mk(128'h8000_0001, 3'd0, 4, 32, 0);
      chk("pin_lsl", m.d, 128'h10);
      chk("pin_lsl_c", 128'(m.c), 0);
      m = mk(128'h8000_0001, 3'd1, 4, 32, 0);
      chk("pin_lsr", m.d, 128'h0800_0000);
      m = mk(128'h8000_0001, 3'd3, 4, 32, 0);
      chk("pin_asr", m.d, 128'hF800_0000);
      m = mk(128'h8000_0001, 3'd4, 4, 32, 0);
      chk("pin_rol", m.d, 128'h18);
      chk("pin_rol_c", 128'(m.c), 0);
      m = mk(128'h8000_0001, 3'd5, 4, 32, 0);
      chk("pin_ror", m.d, 128'h1800_0000);
      chk("pin_ror_c", 128'(m.c), 0);
      m = mk(128'hFFFF_FFFF, 3'd1, 31, 32, 0);
      chk("pin_lsr31", m.d, 128'h1);
      chk("pin_lsr31_c", 128'(m.c), 1);
      m = mk(128'h4000_0000, 3'd3, 31, 32, 0);
      chk("pin_asr31", m.d, 128'h0);
      chk("pin_asr31_c", 128'(m.c), 1);
      m = mk(128'h1234_5678, 3'd6, 4, 32, 0);
      chk("pin_err", {m.d[126:0], m.e}, 128'h1);
      m = mk(128'h81, 3'd4, 1, 8, 0);
      chk("pin_rol8", m.d, 128'h03);
      chk("pin_rol8_c", 128'(m.c), 1);

      #10 reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int op = 0; op < 6; op++)
         send_a(32'h8000_0001, 3'(op), 5'd4);
      idle(4);

      send_a(32'hFFFF_FFFF, 3'd1, 5'd31);
      send_a(32'h0000_0001, 3'd0, 5'd0);
      send_a(32'h4000_0000, 3'd3, 5'd31);
      send_a(32'h1234_5678, 3'd6, 5'd4);
      send_a(32'h1234_5678, 3'd7, 5'd0);
      send_a(32'hA5A5_0F0F, 3'd4, 5'd0);
      idle(4);

      la = 1'b0;
      p0 = popa;
      seen = acca;
      ia.out_ready = 1'b0;
      fork
         begin
            send_a(32'h0000_00F1, 3'd0, 5'd1);
            send_a(32'h0000_00F2, 3'd1, 5'd2);
            send_a(32'h0000_00F3, 3'd4, 5'd3);
            send_a(32'h0000_00F4, 3'd5, 5'd4);
         end
         begin
            repeat (6) @(negedge clk);
            chk("bp_in_ready", 128'(ia.in_ready), 0);
            chk("bp_accepts", 128'(acca - seen), 2);
            chk("bp_out_valid", 128'(ia.out_valid), 1);
            @(posedge clk);
            #1;
            ia.out_ready = 1'b1;
         end
      join
      idle(6);
      chk("bp_delivered", 128'(popa - p0), 4);
      chk("bp_drained", 128'(qa.size()), 0);
      la = 1'b1;

      send_a(32'h1111_1111, 3'd0, 5'd1);
      send_a(32'h2222_2222, 3'd1, 5'd2);
      chk("rst_pre_valid", 128'(ia.out_valid), 1);
      #1 reset_n = 1'b0;
      #1;
      chk("rst_async_valid", 128'(ia.out_valid), 0);
      chk("rst_mid_ready", 128'(ia.in_ready), 1);
      @(negedge clk);
      #2 reset_n = 1'b1;
      p0 = popa;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (ia.out_valid) seen++;
      end
      chk("rst_no_stale", 128'(seen), 0);
      @(posedge clk);
      #1;
      send_a(32'h3333_3333, 3'd5, 5'd8);
      idle(4);
      chk("rst_new_done", 128'(popa - p0), 1);

      fork
         run_b(100, 1'b0);
         run_c(100, 1'b0);
      join
      idle(20);
      lb = 1'b0;
      lc = 1'b0;
      fork
         run_b(100, 1'b1);
         run_c(100, 1'b1);
      join
      idle(30);
      chk("b_drained", 128'(qb.size()), 0);
      chk("c_drained", 128'(qc.size()), 0);
      chk("b_count", 128'(popb), 200);
      chk("c_count", 128'(popc), 200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
